// File: rtl/ccm_ctr_xor.sv
// CCM CTR payload stage: buffers payload blocks, requests one keystream block each, XORs and byte-masks.
// Optional keystream wait watchdog enabled by defining CCM_CTR_XOR_TIMEOUT_EN.
module ccm_ctr_xor #(
    parameter  int WIDTH_BLK   = 128,
    parameter  int FIFO_DEPTH  = 4,
    parameter  int TIMEOUT     = 64,
    localparam int WIDTH_BYTES = $clog2(WIDTH_BLK / 8)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH_BLK-1:0]   in_data,
    input  logic [WIDTH_BYTES-1:0] in_bytes,
    input  logic                   in_last,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   ks_req,
    input  logic [WIDTH_BLK-1:0]   ks_data,
    input  logic                   ks_valid,
    output logic [WIDTH_BLK-1:0]   out_data,
    output logic [WIDTH_BYTES-1:0] out_bytes,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   ks_unexp,
    output logic                   ks_timeout
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int NB    = WIDTH_BLK / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

    typedef struct packed {
        logic [WIDTH_BLK-1:0]   data;
        logic [WIDTH_BYTES-1:0] bytes;
        logic                   last;
    } entry_t;

    state_t                 state_q, state_d;
    entry_t                 mem_q [FIFO_DEPTH];
    entry_t                 head;
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic                   push, pop;
    logic [WIDTH_BLK-1:0]   mask;
    logic [WIDTH_BLK-1:0]   out_data_q;
    logic [WIDTH_BYTES-1:0] out_bytes_q;
    logic                   out_last_q, out_valid_q, ks_unexp_q;

    assign in_ready = (count_q != CNT_W'(FIFO_DEPTH));
    assign push     = in_valid & in_ready;
    assign pop      = (state_q == WAIT) & ks_valid;
    assign head     = mem_q[rd_ptr_q];
    assign ks_req   = (state_q == REQ);

    // NOTE: payload storage has no reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{data: in_data, bytes: in_bytes, last: in_last};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_q != '0) state_d = REQ;
            REQ:     state_d = WAIT;
            WAIT:    if (ks_valid) state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Byte count n keeps the n most significant bytes; 0 keeps the whole block.
    always_comb begin
        mask = '0;
        for (int b = 0; b < NB; b++) begin
            if (head.bytes == '0 || (NB - 1 - b) < int'(head.bytes)) begin
                mask[b*8 +: 8] = 8'hFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_bytes_q <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ks_unexp_q  <= 1'b0;
        end else begin
            if (pop) begin
                out_data_q  <= (head.data ^ ks_data) & mask;
                out_bytes_q <= head.bytes;
                out_last_q  <= head.last;
                out_valid_q <= 1'b1;
            end else if (state_q == OUT && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (ks_valid && state_q != WAIT) ks_unexp_q <= 1'b1;
        end
    end

    assign out_data  = out_data_q;
    assign out_bytes = out_bytes_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign ks_unexp  = ks_unexp_q;

`ifdef CCM_CTR_XOR_TIMEOUT_EN
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    logic [WCNT_W-1:0] wait_cnt_q;
    logic              ks_timeout_q;

    // WAIT is only entered from REQ, so clearing in REQ clears on entry; the count saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q   <= '0;
            ks_timeout_q <= 1'b0;
        end else begin
            if (state_q == REQ) begin
                wait_cnt_q <= '0;
            end else if (state_q == WAIT && wait_cnt_q != WCNT_W'(TIMEOUT)) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            if (state_q == WAIT && wait_cnt_q == WCNT_W'(TIMEOUT - 1)) ks_timeout_q <= 1'b1;
        end
    end

    assign ks_timeout = ks_timeout_q;
`else
    assign ks_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ccm_ctr_xor.sv
// Directed scoreboard bench for ccm_ctr_xor (128-bit blocks, 4-entry FIFO, TIMEOUT=8).
module tb_ccm_ctr_xor;
    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] in_data;
    logic [3:0]   in_bytes;
    logic         in_last, in_valid, in_ready;
    logic         ks_req;
    logic [127:0] ks_data;
    logic         ks_valid;
    logic [127:0] out_data;
    logic [3:0]   out_bytes;
    logic         out_last, out_valid, out_ready;
    logic         ks_unexp, ks_timeout;

    ccm_ctr_xor #(.WIDTH_BLK(128), .FIFO_DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_bytes(in_bytes), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .ks_req(ks_req), .ks_data(ks_data), .ks_valid(ks_valid),
        .out_data(out_data), .out_bytes(out_bytes), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .ks_unexp(ks_unexp), .ks_timeout(ks_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   bytes;
        logic         last;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] ks_q[$];
    int           errors = 0;
    int           checks = 0;
    int           ks_req_cnt = 0;
    int           ks_served = 0;
    logic [127:0] last_out;

    always @(negedge clk) if (ks_req === 1'b1) ks_req_cnt <= ks_req_cnt + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, required finish before 300000");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed no event, required event within bound", tag);
    endtask

    function automatic logic [127:0] mask_of(input logic [3:0] b);
        logic [127:0] ones = '1;
        if (b == 4'd0) return ones;
        return ~(ones >> (8 * b));
    endfunction

    task automatic push_blk(input logic [127:0] d, input logic [3:0] b, input logic l,
                            input logic [127:0] ks);
        exp_t e;
        int   n = 0;
        while (in_ready !== 1'b1 && n < 200) begin step(); n++; end
        if (in_ready !== 1'b1) begin bound_fail("push_ready"); return; end
        in_data = d; in_bytes = b; in_last = l; in_valid = 1'b1;
        e.data = (d ^ ks) & mask_of(b); e.bytes = b; e.last = l;
        exp_q.push_back(e);
        ks_q.push_back(ks);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (ks_req !== 1'b1 && n < 100) begin step(); n++; end
        if (ks_req !== 1'b1) bound_fail("wait_ks_req");
    endtask

    task automatic serve(input int gap);
        int n = 0;
        while (ks_req_cnt <= ks_served && n < 100) begin step(); n++; end
        if (ks_req_cnt <= ks_served) begin bound_fail("serve_req"); return; end
        repeat (gap) step();
        ks_valid = 1'b1;
        ks_data  = ks_q.pop_front();
        ks_served++;
        step();
        ks_valid = 1'b0;
        ks_data  = '0;
    endtask

    task automatic expect_out(input string tag);
        exp_t e;
        int   n = 0;
        while (out_valid !== 1'b1 && n < 100) begin step(); n++; end
        if (out_valid !== 1'b1) begin bound_fail({tag, "_valid"}); return; end
        if (exp_q.size() == 0) begin bound_fail({tag, "_scoreboard"}); return; end
        e = exp_q.pop_front();
        last_out = out_data;
        check({tag, "_data"}, out_data, e.data);
        check({tag, "_bytes"}, 128'(out_bytes), 128'(e.bytes));
        check({tag, "_last"}, 128'(out_last), 128'(e.last));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        exp_q.delete();
        ks_q.delete();
        step();
        ks_served = ks_req_cnt;
    endtask

    initial begin
        logic [127:0] d0;
        int           r0;
        logic         stable;
        int           n;

        reset = 1'b1; in_data = '0; in_bytes = '0; in_last = 1'b0; in_valid = 1'b0;
        ks_data = '0; ks_valid = 1'b0; out_ready = 1'b0;
        repeat (3) step();
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_ks_req", 128'(ks_req), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", out_data, 128'(0));
        check("rst_out_bytes", 128'(out_bytes), 128'(0));
        check("rst_out_last", 128'(out_last), 128'(0));
        check("rst_ks_unexp", 128'(ks_unexp), 128'(0));
        check("rst_ks_timeout", 128'(ks_timeout), 128'(0));
        reset = 1'b0;
        step();

        // Single full block with the request/response latencies pinned down.
        push_blk(128'h000102030405060708090A0B0C0D0E0F, 4'd0, 1'b1, '1);
        check("t1_req_cycle1", 128'(ks_req), 128'(0));
        step();
        check("t1_req_cycle2", 128'(ks_req), 128'(1));
        repeat (4) step();
        ks_valid = 1'b1; ks_data = ks_q.pop_front(); ks_served++;
        step();
        ks_valid = 1'b0;
        check("t1_out_valid_k1", 128'(out_valid), 128'(1));
        expect_out("t1");
        check("t1_inverse", last_out, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
        repeat (3) step();
        check("t1_one_req", 128'(ks_req_cnt), 128'(1));

        // Partial block: five most significant bytes survive.
        push_blk({16{8'hAA}}, 4'd5, 1'b0, {16{8'h55}});
        serve(1);
        expect_out("t2");
        check("t2_const", last_out, 128'hFFFFFFFFFF0000000000000000000000);

        // Fill the FIFO while keystream is withheld.
        for (int i = 0; i < 4; i++) begin
            push_blk({$urandom, $urandom, $urandom, $urandom}, 4'((i * 3) % 16), 1'(i == 3),
                     {$urandom, $urandom, $urandom, $urandom});
        end
        check("t3_full", 128'(in_ready), 128'(0));
        in_data = 128'hDEADBEEF_00112233_44556677_8899AABB; in_bytes = 4'd9; in_last = 1'b1;
        in_valid = 1'b1;
        begin
            exp_t e;
            logic [127:0] ks5 = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
            e.data = (in_data ^ ks5) & mask_of(in_bytes); e.bytes = in_bytes; e.last = in_last;
            exp_q.push_back(e);
            ks_q.push_back(ks5);
        end
        repeat (3) step();
        check("t3_still_full", 128'(in_ready), 128'(0));
        serve(1);
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin step(); n++; end
        if (in_ready !== 1'b1) bound_fail("t3_space");
        step();
        in_valid = 1'b0;
        expect_out("t3_0");
        for (int i = 1; i < 5; i++) begin
            serve(2);
            expect_out($sformatf("t3_%0d", i));
        end

        // Backpressure holds output and blocks further requests.
        push_blk(128'h0123456789ABCDEF_FEDCBA9876543210, 4'd0, 1'b0, 128'h5A5A5A5A_A5A5A5A5_3C3C3C3C_C3C3C3C3);
        push_blk(128'h1111111122222222_3333333344444444, 4'd12, 1'b1, 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000);
        serve(1);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
        if (out_valid !== 1'b1) bound_fail("t4_valid");
        d0 = out_data; r0 = ks_req_cnt; stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid !== 1'b1 || out_data !== d0) stable = 1'b0;
        end
        check("t4_stable", 128'(stable), 128'(1));
        check("t4_no_req", 128'(ks_req_cnt), 128'(r0));
        expect_out("t4_a");
        check("t4_req_h1", 128'(ks_req), 128'(0));
        step();
        check("t4_req_h2", 128'(ks_req), 128'(1));
        serve(1);
        expect_out("t4_b");

        // Stray keystream in IDLE.
        repeat (2) step();
        ks_valid = 1'b1; ks_data = '1;
        step();
        ks_valid = 1'b0; ks_data = '0;
        check("t5_unexp", 128'(ks_unexp), 128'(1));
        check("t5_no_out", 128'(out_valid), 128'(0));
        do_reset();
        check("t5_unexp_clr", 128'(ks_unexp), 128'(0));

        // Reset while waiting for keystream, then a late keystream arrives.
        push_blk(128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D, 4'd0, 1'b1, '0);
        wait_req();
        step();
        do_reset();
        check("t6_in_ready", 128'(in_ready), 128'(1));
        check("t6_out_valid", 128'(out_valid), 128'(0));
        ks_valid = 1'b1; ks_data = '1;
        step();
        ks_valid = 1'b0; ks_data = '0;
        check("t6_late_unexp", 128'(ks_unexp), 128'(1));
        repeat (5) step();
        check("t6_flushed", 128'(ks_req_cnt), 128'(ks_served));
        check("t6_no_out", 128'(out_valid), 128'(0));
        do_reset();

        // Keystream withheld past the wait limit.
        push_blk(128'h00FF00FF_00FF00FF_00FF00FF_00FF00FF, 4'd3, 1'b1, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000);
        wait_req();
`ifdef CCM_CTR_XOR_TIMEOUT_EN
        repeat (8) step();
        check("t7_before_limit", 128'(ks_timeout), 128'(0));
        step();
        check("t7_timeout", 128'(ks_timeout), 128'(1));
        check("t7_no_rereq", 128'(ks_req), 128'(0));
`else
        repeat (12) step();
        check("t7_timeout_off", 128'(ks_timeout), 128'(0));
`endif
        serve(1);
        expect_out("t7");
        repeat (4) step();
        check("end_req_count", 128'(ks_req_cnt), 128'(ks_served));
        check("end_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ccm_ctr_xor.md
# ccm_ctr_xor

CTR-mode payload stage of the CCM datapath, directly downstream of the encrypted-counter block. Buffers incoming plaintext/ciphertext blocks in a small FIFO and issues one keystream request per block. Each returned keystream block is XORed with the FIFO head and byte-masked. The result is presented on a valid/ready output with last/byte-count side-band.

## Interface
- `WIDTH_BLK`, 128: block width in bits; multiple of 8; equals the counter block's key width.
- `FIFO_DEPTH`, 4: payload FIFO entries; power of 2, ≥2.
- `WIDTH_BYTES`, `$clog2(WIDTH_BLK/8)`: byte-count field width (localparam).
- `TIMEOUT`, 64: keystream wait limit in cycles; used only with `CCM_CTR_XOR_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `in_data`  in  WIDTH_BLK  payload block.
- `in_bytes`  in  WIDTH_BYTES  valid byte count; 0 = all bytes valid.
- `in_last`  in  1  last block of message.
- `in_valid`  in  1  input handshake valid.
- `in_ready`  out  1  input handshake ready.
- `ks_req`  out  1  one-cycle keystream request; drives counter block `input_en_buf`.
- `ks_data`  in  WIDTH_BLK  keystream block (counter block `encrypt_data`).
- `ks_valid`  in  1  keystream valid, single-cycle (counter block `encrypt_en`).
- `out_data`  out  WIDTH_BLK  XOR result, masked.
- `out_bytes`  out  WIDTH_BYTES  copy of `in_bytes` for this block.
- `out_last`  out  1  copy of `in_last` for this block.
- `out_valid`  out  1  output handshake valid.
- `out_ready`  in  1  output handshake ready.
- `ks_unexp`  out  1  sticky: `ks_valid` seen outside WAIT.
- `ks_timeout`  out  1  sticky: WAIT exceeded `TIMEOUT` (0 when macro off).

## Operation
- FIFO entry = {data, bytes, last}. Push on `in_valid & in_ready`. `in_ready` = FIFO not full (registered count). Pop on keystream capture.
- FSM states IDLE, REQ, WAIT, OUT:
  - IDLE → REQ when FIFO non-empty.
  - REQ: `ks_req`=1 for exactly this cycle; → WAIT.
  - WAIT: on `ks_valid`, `out_data` ← (head.data ^ `ks_data`) & mask, capture bytes/last, `out_valid`←1, pop; → OUT.
  - OUT: when `out_ready`, `out_valid`←0; → IDLE.
- Mask: bytes=0 → all ones; bytes=n → top n bytes kept (MSB-first, CCM big-endian), remaining bytes forced 0.
- Exactly one `ks_req` per FIFO entry; never a second request before capture.
- `ks_valid` in IDLE/REQ/OUT: ignored, `ks_unexp`←1 (sticky until reset).
- Push and pop in the same cycle: count unchanged. Push when full: impossible (`in_ready`=0).
- Pointers wrap modulo `FIFO_DEPTH`; count width holds 0..FIFO_DEPTH.

## Timing
- Reset values: `in_ready`=1, `ks_req`=0, `out_valid`=0, `out_data`=0, `out_bytes`=0, `out_last`=0, `ks_unexp`=0, `ks_timeout`=0; FIFO empty; state IDLE.
- Push at cycle 0 into an empty FIFO → IDLE sees non-empty in cycle 1 → `ks_req` high in cycle 2 → WAIT from cycle 3.
- `ks_valid` in cycle k (in WAIT) → `out_valid` high in cycle k+1.
- `out_valid` holds with stable data until `out_ready`; earliest next `ks_req` is 2 cycles after the handshake cycle.
- Reset mid-operation flushes the FIFO and any pending output. A late `ks_valid` after reset sets `ks_unexp`. The counter block shares the same reset.

## Configuration
- `CCM_CTR_XOR_TIMEOUT_EN` defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT`, `ks_timeout`←1 (sticky). The FSM stays in WAIT and does not re-request.
- Undefined: no counter; `ks_timeout` tied 0.

## Test plan
- Single full block: push data=0x00..0F pattern, bytes=0, last=1. Reply `ks_valid` 4 cycles after `ks_req` with ks=all 0xFF → `out_data`=bitwise inverse, `out_last`=1, exactly one `ks_req`.
- Partial block: bytes=5, data=all 0xAA, ks=all 0x55 → `out_data` top 5 bytes 0xFF, low 11 bytes 0x00, `out_bytes`=5.
- Fill FIFO: push 5 blocks back-to-back with `ks_valid` withheld → `in_ready`=0 after 4 accepts. Then serve keystream → 4 outputs in order, fifth accepted once space frees.
- Backpressure: hold `out_ready`=0 for 10 cycles → `out_valid`/`out_data` stable, no new `ks_req`. Release → next `ks_req` 2 cycles later.
- Stray keystream: pulse `ks_valid` in IDLE → `ks_unexp`=1, no output. Reset → `ks_unexp`=0.
- With `CCM_CTR_XOR_TIMEOUT_EN`, `TIMEOUT`=8: withhold `ks_valid` → `ks_timeout`=1 after 8 WAIT cycles. Late `ks_valid` still produces the output.
